// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_gen
//  Purpose  : Drives an LW-bit LED bank from a prescaled tick in one of four
//             run-time selectable modes: binary count, bouncing scan, PWM
//             breathe and rotating pattern. Includes a run enable, a restart
//             on every mode change, and an exported one-cycle tick pulse.
//  Ports    : clk    - system clock
//             rst_n  - asynchronous active-low reset (released on clk edge)
//             en     - run enable; low freezes prescaler, PWM and mode state
//             mode   - 0=COUNT, 1=SCAN, 2=BREATHE, 3=ROTATE
//             pat    - seed pattern captured on entry to ROTATE
//             leds   - LED drive, active high
//             tick   - registered pulse, one cycle per prescaler wrap
//  Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
  parameter int LW    = 8,
  parameter int DIV   = 8388608,
  parameter int PWM_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [LW-1:0] pat,
  output logic [LW-1:0] leds,
  output logic          tick
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  // A divide ratio of 1 still needs a one-bit prescaler so the wrap compare
  // has something to look at; it simply stays at zero.
  localparam int PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int POS_W = $clog2(LW);

  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LW - 1);
  localparam logic [POS_W-1:0] POS_PREV = POS_W'(LW - 2);
  localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] DUTY_PRV = DUTY_MAX - PWM_W'(1);

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_ROTATE  = 2'd3
  } mode_e;

  // Direction encodings for the two bouncing sequences.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  mode_e            mode_q;
  logic [PSC_W-1:0] psc;
  logic [LW-1:0]    cnt;
  logic [POS_W-1:0] pos;
  logic             dir;
  logic [PWM_W-1:0] duty;
  logic             ddir;
  logic [PWM_W-1:0] pwm;
  logic [LW-1:0]    rot;

  // --------------------------------------------------------------------------
  // Control strobes
  // --------------------------------------------------------------------------
  // A mode change overrides everything else on its edge, including a
  // disabled enable, so the restart is never lost while frozen.
  logic restart;
  logic psc_wrap;

  assign restart  = (mode != mode_q);
  assign psc_wrap = (psc == PSC_LAST);

  // --------------------------------------------------------------------------
  // Sequential core: prescaler, tick and per-mode pattern state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_COUNT;
      psc    <= '0;
      tick   <= 1'b0;
      cnt    <= '0;
      pos    <= '0;
      dir    <= DIR_UP;
      duty   <= '0;
      ddir   <= DIR_UP;
      pwm    <= '0;
      rot    <= '0;
    end else if (restart) begin
      // Every mode starts from a clean slate; ROTATE captures its seed here,
      // which is the only way into that mode (mode_q resets to COUNT).
      mode_q <= mode_e'(mode);
      psc    <= '0;
      tick   <= 1'b0;
      cnt    <= '0;
      pos    <= '0;
      dir    <= DIR_UP;
      duty   <= '0;
      ddir   <= DIR_UP;
      pwm    <= '0;
      rot    <= pat;
    end else if (en) begin
      // PWM carrier runs every enabled cycle, independent of the prescaler.
      pwm <= pwm + 1'b1;

      if (psc_wrap) begin
        psc  <= '0;
        tick <= 1'b1;

        // Only the active mode's state advances on a tick.
        case (mode_q)
          MODE_COUNT: begin
            cnt <= cnt + 1'b1;
          end

          MODE_SCAN: begin
            // Bounce without dwelling on either end position.
            if (dir == DIR_UP) begin
              if (pos == POS_LAST) begin
                pos <= POS_PREV;
                dir <= DIR_DOWN;
              end else begin
                pos <= pos + 1'b1;
              end
            end else begin
              if (pos == '0) begin
                pos <= POS_W'(1);
                dir <= DIR_UP;
              end else begin
                pos <= pos - 1'b1;
              end
            end
          end

          MODE_BREATHE: begin
            // Same no-repeat triangle as SCAN, over the full duty range.
            if (ddir == DIR_UP) begin
              if (duty == DUTY_MAX) begin
                duty <= DUTY_PRV;
                ddir <= DIR_DOWN;
              end else begin
                duty <= duty + 1'b1;
              end
            end else begin
              if (duty == '0) begin
                duty <= PWM_W'(1);
                ddir <= DIR_UP;
              end else begin
                duty <= duty - 1'b1;
              end
            end
          end

          MODE_ROTATE: begin
            rot <= {rot[LW-2:0], rot[LW-1]};
          end

          default: begin
          end
        endcase
      end else begin
        psc  <= psc + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      // Disabled: everything holds, but a pending tick must not stretch.
      tick <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // LED output select (combinational from registered state only)
  // --------------------------------------------------------------------------
  always_comb begin
    leds = '0;
    case (mode_q)
      MODE_COUNT:   leds = cnt;
      MODE_SCAN:    leds = LW'(1) << pos;
      MODE_BREATHE: leds = (pwm < duty) ? {LW{1'b1}} : {LW{1'b0}};
      MODE_ROTATE:  leds = rot;
      default:      leds = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pattern_gen
//  Purpose  : Directed self-checking bench for led_pattern_gen. A LW=4,
//             DIV=4, PWM_W=3 instance walks through COUNT, enable freeze,
//             SCAN, async reset, BREATHE and ROTATE; a DIV=1 instance checks
//             the every-cycle tick case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

  localparam int LW    = 4;
  localparam int DIV   = 4;
  localparam int PWM_W = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en;
  logic          en1;
  logic [1:0]    mode;
  logic [1:0]    mode1;
  logic [LW-1:0] pat;
  logic [LW-1:0] pat1;
  logic [LW-1:0] leds;
  logic [LW-1:0] leds1;
  logic          tick;
  logic          tick1;

  int n_pass  = 0;
  int n_total = 0;
  int k       = 0;   // enabled cycles since the COUNT restart

  always #5 clk = ~clk;

  led_pattern_gen #(.LW(LW), .DIV(DIV), .PWM_W(PWM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .pat   (pat),
    .leds  (leds),
    .tick  (tick)
  );

  led_pattern_gen #(.LW(LW), .DIV(1), .PWM_W(PWM_W)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en1),
    .mode  (mode1),
    .pat   (pat1),
    .leds  (leds1),
    .tick  (tick1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One enabled COUNT cycle: tick every 4th edge, leds = ticks mod 16.
  task automatic cnt_step();
    cyc();
    k++;
    check("cnt_tick", tick, (k % 4) == 0);
    check("cnt_leds", leds, (k / 4) % 16);
  endtask

  // Four cycles spanning one tick: leds holds 'prev', then shows 'nxt'.
  task automatic tick_seq(input string tag, input logic [3:0] prev, input logic [3:0] nxt);
    for (int c = 0; c < 3; c++) begin
      cyc();
      check({tag, "_hold"}, leds, prev);
      check({tag, "_notick"}, tick, 1'b0);
    end
    cyc();
    check({tag, "_next"}, leds, nxt);
    check({tag, "_tick"}, tick, 1'b1);
  endtask

  logic [3:0] scan_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                               4'b0010, 4'b0001, 4'b0010};
  logic [3:0] rot_exp  [5] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011};

  initial begin
    en = 1'b0; en1 = 1'b0; mode = 2'd0; mode1 = 2'd0;
    pat = '0; pat1 = '0;

    // ---------------- reset ----------------
    #1 rst_n = 1'b0;
    #2;
    check("rst_leds",  leds,  4'h0);
    check("rst_tick",  tick,  1'b0);
    check("rst_leds1", leds1, 4'h0);
    check("rst_tick1", tick1, 1'b0);
    #19 rst_n = 1'b1;           // released between edges
    en  = 1'b1;
    en1 = 1'b1;

    // ---------------- COUNT with wrap, plus DIV=1 ----------------
    for (int i = 0; i < 84; i++) begin
      cnt_step();
      if (k <= 20) begin
        check("div1_tick", tick1, 1'b1);
        check("div1_leds", leds1, k % 16);
      end
    end
    en1 = 1'b0;
    cnt_step();
    check("div1_off_tick", tick1, 1'b0);
    check("div1_off_leds", leds1, 4'h4);
    cnt_step();                  // k=86: leds=5, psc=2

    // ---------------- enable freeze ----------------
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("frz_leds", leds, 4'h5);
      check("frz_tick", tick, 1'b0);
    end
    en = 1'b1;
    cnt_step();                  // psc 2->3, no tick
    cnt_step();                  // tick, leds=6
    cnt_step();                  // psc=1, mid-count

    // ---------------- COUNT -> SCAN ----------------
    mode = 2'd1;
    cyc();
    check("scan_entry_leds", leds, 4'b0001);
    check("scan_entry_tick", tick, 1'b0);
    begin
      logic [3:0] prev;
      prev = 4'b0001;
      for (int i = 0; i < 7; i++) begin
        tick_seq("scan", prev, scan_exp[i]);
        prev = scan_exp[i];
      end
    end

    // ---------------- async reset mid-SCAN ----------------
    #2 rst_n = 1'b0;
    #1;
    check("arst_leds", leds, 4'h0);
    check("arst_tick", tick, 1'b0);
    #4 rst_n = 1'b1;
    cyc();
    check("scan_rst_entry", leds, 4'b0001);
    tick_seq("scan_rst", 4'b0001, 4'b0010);

    // ---------------- BREATHE ----------------
    mode = 2'd2;
    cyc();
    check("br_entry_leds", leds, 4'h0);
    check("br_entry_tick", tick, 1'b0);
    for (int j = 1; j <= 64; j++) begin
      int pwm_m, m, duty_m;
      cyc();
      pwm_m  = j % 8;
      m      = (j / 4) % 14;
      duty_m = (m <= 7) ? m : 14 - m;
      check("br_leds", leds, (pwm_m < duty_m) ? 4'hF : 4'h0);
      check("br_tick", tick, (j % 4) == 0);
    end

    // ---------------- COUNT -> ROTATE ----------------
    mode = 2'd0;
    cyc();
    check("rot_pre_leds", leds, 4'h0);
    pat  = 4'b0011;
    mode = 2'd3;
    cyc();
    check("rot_entry", leds, 4'b0011);
    pat = 4'b1010;               // ignored while in ROTATE
    for (int i = 1; i < 5; i++)
      tick_seq("rot", rot_exp[i-1], rot_exp[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
